rv64_decode_exec: RTL and testbench

- Combinational RV64I decode-and-execute slice of the single-cycle NPC, plus a registered reset-release stage.
- Takes the fetched instruction, current PC and register-file read data.
- Produces register addresses and write enable, immediate, load/store opcode, control-flow flags, ALU result and decode-error flags.
- Sits between the IFU/regfile and the LSU/WBU/PCU.

---
 rtl/rv64_pkg.sv | 43 ++++
 rtl/rv64_alu.sv | 64 ++++++
 rtl/rv64_decode_exec.sv | 215 +++++++++++++++++++++
 tb/tb_rv64_decode_exec.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv64_pkg.sv
// Shared RV64I decode definitions: major opcodes, EXU operation set,
// load/store opcode encodings and immediate formats.
package rv64_pkg;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
   localparam logic [6:0] OPC_OP32     = 7'b0111011;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   typedef enum logic [4:0] {
      EXU_ADD, EXU_SUB, EXU_SLL, EXU_SLT, EXU_SLTU, EXU_XOR, EXU_SRL, EXU_SRA,
      EXU_OR, EXU_AND, EXU_ADDW, EXU_SUBW, EXU_SLLW, EXU_SRLW, EXU_SRAW,
      EXU_LUI, EXU_AUIPC, EXU_LINK,
      EXU_BEQ, EXU_BNE, EXU_BLT, EXU_BGE, EXU_BLTU, EXU_BGEU
   } exu_op_e;

   // {unsigned, size[1:0], store, not_load}
   localparam logic [4:0] LSU_NONE = 5'b00001;
   localparam logic [4:0] LSU_LB   = 5'b00000;
   localparam logic [4:0] LSU_LH   = 5'b00100;
   localparam logic [4:0] LSU_LW   = 5'b01000;
   localparam logic [4:0] LSU_LD   = 5'b01100;
   localparam logic [4:0] LSU_LBU  = 5'b10000;
   localparam logic [4:0] LSU_LHU  = 5'b10100;
   localparam logic [4:0] LSU_LWU  = 5'b11000;
   localparam logic [4:0] LSU_SB   = 5'b00011;
   localparam logic [4:0] LSU_SH   = 5'b00111;
   localparam logic [4:0] LSU_SW   = 5'b01011;
   localparam logic [4:0] LSU_SD   = 5'b01111;

   typedef enum logic [2:0] {
      IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
   } imm_type_e;

endpackage

// File: rtl/rv64_alu.sv
// Pure combinational EXU: arithmetic/logic, word ops, link address and
// branch condition (result LSB is the inverted taken flag).
module rv64_alu
   import rv64_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  exu_op_e         op,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [XLEN-1:0] imm,
   input  logic            use_imm,
   output logic [XLEN-1:0] res
);

   logic [XLEN-1:0] op_b;
   logic [31:0]     w_res;
   logic            taken;
   logic            is_word;
   logic            is_branch;

   assign op_b      = use_imm ? imm : rs2;
   assign is_word   = op inside {EXU_ADDW, EXU_SUBW, EXU_SLLW, EXU_SRLW, EXU_SRAW};
   assign is_branch = op inside {EXU_BEQ, EXU_BNE, EXU_BLT, EXU_BGE, EXU_BLTU, EXU_BGEU};

   always_comb begin
      res   = '0;
      w_res = '0;
      taken = 1'b0;
      case (op)
         EXU_ADD:   res = rs1 + op_b;
         EXU_SUB:   res = rs1 - op_b;
         EXU_SLL:   res = rs1 << op_b[5:0];
         EXU_SLT:   res = {{(XLEN-1){1'b0}}, $signed(rs1) < $signed(op_b)};
         EXU_SLTU:  res = {{(XLEN-1){1'b0}}, rs1 < op_b};
         EXU_XOR:   res = rs1 ^ op_b;
         EXU_SRL:   res = rs1 >> op_b[5:0];
         EXU_SRA:   res = $signed(rs1) >>> op_b[5:0];
         EXU_OR:    res = rs1 | op_b;
         EXU_AND:   res = rs1 & op_b;
         EXU_ADDW:  w_res = rs1[31:0] + op_b[31:0];
         EXU_SUBW:  w_res = rs1[31:0] - op_b[31:0];
         EXU_SLLW:  w_res = rs1[31:0] << op_b[4:0];
         EXU_SRLW:  w_res = rs1[31:0] >> op_b[4:0];
         EXU_SRAW:  w_res = $signed(rs1[31:0]) >>> op_b[4:0];
         EXU_LUI:   res = imm;
         EXU_AUIPC: res = pc + imm;
         EXU_LINK:  res = pc + XLEN'(4);
         EXU_BEQ:   taken = (rs1 == rs2);
         EXU_BNE:   taken = (rs1 != rs2);
         EXU_BLT:   taken = ($signed(rs1) < $signed(rs2));
         EXU_BGE:   taken = ($signed(rs1) >= $signed(rs2));
         EXU_BLTU:  taken = (rs1 < rs2);
         EXU_BGEU:  taken = (rs1 >= rs2);
         default:   res = '0;
      endcase
      if (is_word)
         res = {{(XLEN-32){w_res[31]}}, w_res};
      if (is_branch)
         res = {{(XLEN-1){1'b0}}, ~taken};
   end

endmodule

// File: rtl/rv64_decode_exec.sv
// RV64I decode-and-execute slice with a two-flop reset-release stage;
// illegal encodings and the reset window squash side effects to a NOP.
module rv64_decode_exec
   import rv64_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int ILEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   output logic               o_rst_sync,
   input  logic [ILEN-1:0]    i_inst,
   input  logic [XLEN-1:0]    i_pc,
   input  logic [XLEN-1:0]    i_rs1_data,
   input  logic [XLEN-1:0]    i_rs2_data,
   output logic [RADDR_W-1:0] o_rs1_addr,
   output logic [RADDR_W-1:0] o_rs2_addr,
   output logic [RADDR_W-1:0] o_rd_addr,
   output logic               o_rd_wen,
   output logic [XLEN-1:0]    o_imm,
   output logic [4:0]         o_lsu_opt,
   output logic               o_brch,
   output logic               o_jal,
   output logic               o_jalr,
   output logic [XLEN-1:0]    o_exu_res,
   output logic               o_zero,
   output logic [2:0]         o_id_err
);

   logic rst_meta_reg;
   logic rst_sync_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         rst_meta_reg <= 1'b1;
         rst_sync_reg <= 1'b1;
      end else begin
         rst_meta_reg <= 1'b0;
         rst_sync_reg <= rst_meta_reg;
      end
   end

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   exu_op_e    exu_op;
   imm_type_e  imm_type;
   logic       use_imm;
   logic       rd_wen_dec;
   logic [4:0] lsu_dec;
   logic       brch_dec, jal_dec, jalr_dec;
   logic [2:0] err_dec;
   logic       nop;

   assign opcode = i_inst[6:0];
   assign funct3 = i_inst[14:12];
   assign funct7 = i_inst[31:25];

   always_comb begin
      exu_op     = EXU_ADD;
      imm_type   = IMM_NONE;
      use_imm    = 1'b0;
      rd_wen_dec = 1'b0;
      lsu_dec    = LSU_NONE;
      brch_dec   = 1'b0;
      jal_dec    = 1'b0;
      jalr_dec   = 1'b0;
      err_dec    = 3'b000;
      case (opcode)
         OPC_LUI:   begin imm_type = IMM_U; exu_op = EXU_LUI;   rd_wen_dec = 1'b1; end
         OPC_AUIPC: begin imm_type = IMM_U; exu_op = EXU_AUIPC; rd_wen_dec = 1'b1; end
         OPC_JAL: begin
            imm_type = IMM_J; exu_op = EXU_LINK; rd_wen_dec = 1'b1; jal_dec = 1'b1;
         end
         OPC_JALR: begin
            imm_type = IMM_I; exu_op = EXU_LINK; rd_wen_dec = 1'b1; jalr_dec = 1'b1;
            err_dec[1] = (funct3 != 3'b000);
         end
         OPC_BRANCH: begin
            imm_type = IMM_B;
            brch_dec = 1'b1;
            case (funct3)
               3'b000:  exu_op = EXU_BEQ;
               3'b001:  exu_op = EXU_BNE;
               3'b100:  exu_op = EXU_BLT;
               3'b101:  exu_op = EXU_BGE;
               3'b110:  exu_op = EXU_BLTU;
               3'b111:  exu_op = EXU_BGEU;
               default: err_dec[1] = 1'b1;
            endcase
         end
         OPC_LOAD: begin
            imm_type = IMM_I; use_imm = 1'b1; rd_wen_dec = 1'b1;
            case (funct3)
               3'b000:  lsu_dec = LSU_LB;
               3'b001:  lsu_dec = LSU_LH;
               3'b010:  lsu_dec = LSU_LW;
               3'b011:  lsu_dec = LSU_LD;
               3'b100:  lsu_dec = LSU_LBU;
               3'b101:  lsu_dec = LSU_LHU;
               3'b110:  lsu_dec = LSU_LWU;
               default: err_dec[1] = 1'b1;
            endcase
         end
         OPC_STORE: begin
            imm_type = IMM_S; use_imm = 1'b1;
            case (funct3)
               3'b000:  lsu_dec = LSU_SB;
               3'b001:  lsu_dec = LSU_SH;
               3'b010:  lsu_dec = LSU_SW;
               3'b011:  lsu_dec = LSU_SD;
               default: err_dec[1] = 1'b1;
            endcase
         end
         OPC_OP_IMM: begin
            imm_type = IMM_I; use_imm = 1'b1; rd_wen_dec = 1'b1;
            case (funct3)
               3'b000:  exu_op = EXU_ADD;
               3'b001:  exu_op = EXU_SLL;
               3'b010:  exu_op = EXU_SLT;
               3'b011:  exu_op = EXU_SLTU;
               3'b100:  exu_op = EXU_XOR;
               3'b101:  exu_op = i_inst[30] ? EXU_SRA : EXU_SRL;
               3'b110:  exu_op = EXU_OR;
               default: exu_op = EXU_AND;
            endcase
            // shamt takes inst[25], so only the upper six bits are a function code
            if (funct3 == 3'b001 || funct3 == 3'b101)
               err_dec[2] = !(i_inst[31:26] == 6'b000000 || i_inst[31:26] == 6'b010000);
         end
         OPC_OP: begin
            rd_wen_dec = 1'b1;
            case (funct3)
               3'b000:  exu_op = i_inst[30] ? EXU_SUB : EXU_ADD;
               3'b001:  exu_op = EXU_SLL;
               3'b010:  exu_op = EXU_SLT;
               3'b011:  exu_op = EXU_SLTU;
               3'b100:  exu_op = EXU_XOR;
               3'b101:  exu_op = i_inst[30] ? EXU_SRA : EXU_SRL;
               3'b110:  exu_op = EXU_OR;
               default: exu_op = EXU_AND;
            endcase
            err_dec[2] = !(funct7 == 7'b0000000 ||
                           (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)));
         end
         OPC_OP_IMM32, OPC_OP32: begin
            rd_wen_dec = 1'b1;
            if (opcode == OPC_OP_IMM32) begin
               imm_type = IMM_I;
               use_imm  = 1'b1;
            end
            case (funct3)
               3'b000: begin
                  if (opcode == OPC_OP32) begin
                     exu_op     = i_inst[30] ? EXU_SUBW : EXU_ADDW;
                     err_dec[2] = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
                  end else begin
                     exu_op = EXU_ADDW;
                  end
               end
               3'b001: begin
                  exu_op     = EXU_SLLW;
                  err_dec[2] = (funct7 != 7'b0000000);
               end
               3'b101: begin
                  exu_op     = i_inst[30] ? EXU_SRAW : EXU_SRLW;
                  err_dec[2] = !(funct7 == 7'b0000000 || funct7 == 7'b0100000);
               end
               default: err_dec[1] = 1'b1;
            endcase
         end
         OPC_SYSTEM: begin
         end
         default: err_dec[0] = 1'b1;
      endcase
   end

   always_comb begin
      case (imm_type)
         IMM_I:   o_imm = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
         IMM_S:   o_imm = {{(XLEN-12){i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
         IMM_B:   o_imm = {{(XLEN-13){i_inst[31]}}, i_inst[31], i_inst[7],
                           i_inst[30:25], i_inst[11:8], 1'b0};
         IMM_U:   o_imm = {{(XLEN-32){i_inst[31]}}, i_inst[31:12], 12'b0};
         IMM_J:   o_imm = {{(XLEN-21){i_inst[31]}}, i_inst[31], i_inst[19:12],
                           i_inst[20], i_inst[30:21], 1'b0};
         default: o_imm = '0;
      endcase
   end

   rv64_alu #(.XLEN(XLEN)) u_alu (
      .op      (exu_op),
      .pc      (i_pc),
      .rs1     (i_rs1_data),
      .rs2     (i_rs2_data),
      .imm     (o_imm),
      .use_imm (use_imm),
      .res     (o_exu_res)
   );

   assign nop        = rst_sync_reg | (|err_dec);
   assign o_rst_sync = rst_sync_reg;
   assign o_rs1_addr = i_inst[19:15];
   assign o_rs2_addr = i_inst[24:20];
   assign o_rd_addr  = i_inst[11:7];
   assign o_rd_wen   = rd_wen_dec & ~nop;
   assign o_lsu_opt  = nop ? LSU_NONE : lsu_dec;
   assign o_brch     = brch_dec & ~nop;
   assign o_jal      = jal_dec & ~nop;
   assign o_jalr     = jalr_dec & ~nop;
   assign o_id_err   = rst_sync_reg ? 3'b000 : err_dec;
   assign o_zero     = (o_exu_res == '0);

endmodule

// File: tb/tb_rv64_decode_exec.sv
// Self-checking bench: reset release, directed encodings, then random
// instructions compared against an arithmetic reference model.
module tb_rv64_decode_exec;

   logic        clk = 1'b0;
   logic        rst;
   logic        rst_sync;
   logic [31:0] inst;
   logic [63:0] pc, rs1_data, rs2_data;
   logic [4:0]  rs1_addr, rs2_addr, rd_addr;
   logic        rd_wen;
   logic [63:0] imm;
   logic [4:0]  lsu_opt;
   logic        brch, jal, jalr;
   logic [63:0] exu_res;
   logic        zero;
   logic [2:0]  id_err;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rv64_decode_exec dut (
      .clk        (clk),
      .rst        (rst),
      .o_rst_sync (rst_sync),
      .i_inst     (inst),
      .i_pc       (pc),
      .i_rs1_data (rs1_data),
      .i_rs2_data (rs2_data),
      .o_rs1_addr (rs1_addr),
      .o_rs2_addr (rs2_addr),
      .o_rd_addr  (rd_addr),
      .o_rd_wen   (rd_wen),
      .o_imm      (imm),
      .o_lsu_opt  (lsu_opt),
      .o_brch     (brch),
      .o_jal      (jal),
      .o_jalr     (jalr),
      .o_exu_res  (exu_res),
      .o_zero     (zero),
      .o_id_err   (id_err)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (inst 0x%08h)", tag, got, exp, inst);
      end
   endtask

   typedef struct {
      logic        wen;
      logic        imm_known;
      logic [63:0] imm;
      logic [4:0]  lsu;
      logic        brch, jal, jalr;
      logic [2:0]  err;
      logic        res_known;
      logic [63:0] res;
   } exp_t;

   function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
      longint s;
      s = longint'(v << (64 - bits));
      return s >>> (64 - bits);
   endfunction

   function automatic logic [63:0] alu64(input logic [2:0] f3, input logic alt,
                                         input logic [63:0] a, input logic [63:0] b);
      longint sa = a;
      longint sb = b;
      case (f3)
         3'd0:    return alt ? a - b : a + b;
         3'd1:    return a << b[5:0];
         3'd2:    return (sa < sb) ? 64'd1 : 64'd0;
         3'd3:    return (a < b) ? 64'd1 : 64'd0;
         3'd4:    return a ^ b;
         3'd5:    return alt ? 64'(sa >>> b[5:0]) : a >> b[5:0];
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic [63:0] alu32(input logic [2:0] f3, input logic alt,
                                         input logic [63:0] a, input logic [63:0] b);
      logic [31:0] x;
      int          si;
      si = a[31:0];
      case (f3)
         3'd0:    x = alt ? a[31:0] - b[31:0] : a[31:0] + b[31:0];
         3'd1:    x = a[31:0] << b[4:0];
         default: x = alt ? 32'(si >>> b[4:0]) : a[31:0] >> b[4:0];
      endcase
      return sext({32'b0, x}, 32);
   endfunction

   function automatic exp_t model(input logic [31:0] in, input logic [63:0] p,
                                  input logic [63:0] a, input logic [63:0] b);
      exp_t        e;
      logic [2:0]  f3 = in[14:12];
      logic [6:0]  f7 = in[31:25];
      logic [63:0] imm_i = sext({52'b0, in[31:20]}, 12);
      logic [63:0] imm_s = sext({52'b0, in[31:25], in[11:7]}, 12);
      logic [63:0] imm_b = sext({52'b0, in[31], in[7], in[30:25], in[11:8]}, 12) * 2;
      logic [63:0] imm_u = sext({44'b0, in[31:12]}, 20) * 4096;
      logic [63:0] imm_j = sext({44'b0, in[31], in[19:12], in[20], in[30:21]}, 20) * 2;
      longint      sa = a;
      longint      sb = b;
      logic        tk = 1'b0;
      logic        w_ok;
      e.wen = 0; e.imm_known = 1; e.imm = 64'd0; e.lsu = 5'b00001;
      e.brch = 0; e.jal = 0; e.jalr = 0; e.err = 3'b000; e.res_known = 1; e.res = 64'd0;
      w_ok = (f7 == 7'h00) || (f7 == 7'h20);
      case (in[6:0])
         7'h37: begin e.wen = 1; e.imm = imm_u; e.res = imm_u; end
         7'h17: begin e.wen = 1; e.imm = imm_u; e.res = p + imm_u; end
         7'h6F: begin e.wen = 1; e.jal = 1; e.imm = imm_j; e.res = p + 4; end
         7'h67: begin
            e.wen = 1; e.jalr = 1; e.imm = imm_i; e.res = p + 4;
            e.err[1] = (f3 != 0);
         end
         7'h63: begin
            e.brch = 1; e.imm = imm_b;
            case (f3)
               3'd0: tk = (a == b);
               3'd1: tk = (a != b);
               3'd4: tk = (sa < sb);
               3'd5: tk = (sa >= sb);
               3'd6: tk = (a < b);
               3'd7: tk = (a >= b);
               default: e.err[1] = 1;
            endcase
            e.res = tk ? 64'd0 : 64'd1;
         end
         7'h03: begin
            e.wen = 1; e.imm = imm_i; e.res = a + imm_i;
            e.lsu = {f3[2], f3[1:0], 2'b00};
            e.err[1] = (f3 == 3'd7);
         end
         7'h23: begin
            e.imm = imm_s; e.res = a + imm_s;
            e.lsu = {1'b0, f3[1:0], 2'b11};
            e.err[1] = f3[2];
         end
         7'h13: begin
            e.wen = 1; e.imm = imm_i;
            e.res = alu64(f3, in[30] && f3 == 3'd5, a, imm_i);
            e.err[2] = (f3 == 3'd1 || f3 == 3'd5) && !(in[31:26] == 6'h00 || in[31:26] == 6'h10);
         end
         7'h33: begin
            e.wen = 1; e.imm_known = 0;
            e.res = alu64(f3, f7 == 7'h20, a, b);
            e.err[2] = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
         end
         7'h1B: begin
            e.wen = 1; e.imm = imm_i;
            if (f3 == 3'd0) e.res = alu32(f3, 1'b0, a, imm_i);
            else if (f3 == 3'd1) begin e.res = alu32(f3, 1'b0, a, imm_i); e.err[2] = (f7 != 0); end
            else if (f3 == 3'd5) begin e.res = alu32(f3, f7 == 7'h20, a, imm_i); e.err[2] = !w_ok; end
            else e.err[1] = 1;
         end
         7'h3B: begin
            e.wen = 1; e.imm_known = 0;
            if (f3 == 3'd0 || f3 == 3'd5) begin e.res = alu32(f3, f7 == 7'h20, a, b); e.err[2] = !w_ok; end
            else if (f3 == 3'd1) begin e.res = alu32(f3, 1'b0, a, b); e.err[2] = (f7 != 0); end
            else e.err[1] = 1;
         end
         7'h73: begin e.imm_known = 0; e.res_known = 0; end
         default: begin e.err[0] = 1; e.imm_known = 0; e.res_known = 0; end
      endcase
      if (e.err != 3'b000) begin
         e.wen = 0; e.lsu = 5'b00001; e.brch = 0; e.jal = 0; e.jalr = 0; e.res_known = 0;
      end
      return e;
   endfunction

   task automatic apply(input logic [31:0] i, input logic [63:0] p,
                        input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      inst = i; pc = p; rs1_data = a; rs2_data = b;
      #1;
   endtask

   task automatic check_model();
      exp_t e;
      e = model(inst, pc, rs1_data, rs2_data);
      check_val("rs1_addr", {59'b0, rs1_addr}, {59'b0, inst[19:15]});
      check_val("rs2_addr", {59'b0, rs2_addr}, {59'b0, inst[24:20]});
      check_val("rd_addr", {59'b0, rd_addr}, {59'b0, inst[11:7]});
      check_val("rd_wen", {63'b0, rd_wen}, {63'b0, e.wen});
      check_val("lsu_opt", {59'b0, lsu_opt}, {59'b0, e.lsu});
      check_val("ctrl", {61'b0, brch, jal, jalr}, {61'b0, e.brch, e.jal, e.jalr});
      check_val("id_err", {61'b0, id_err}, {61'b0, e.err});
      if (e.imm_known) check_val("imm", imm, e.imm);
      if (e.res_known) begin
         check_val("exu_res", exu_res, e.res);
         check_val("zero", {63'b0, zero}, {63'b0, e.res == 64'd0});
      end
   endtask

   logic [6:0] opc_tab [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                7'h23, 7'h13, 7'h33, 7'h1B, 7'h3B, 7'h73};

   initial begin
      rst = 1'b1; inst = 32'h00500093; pc = 64'h0; rs1_data = 64'h10; rs2_data = 64'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_sync_in_reset", {63'b0, rst_sync}, 64'd1);
      check_val("rd_wen_in_reset", {63'b0, rd_wen}, 64'd0);
      check_val("lsu_in_reset", {59'b0, lsu_opt}, 64'd1);
      check_val("imm_in_reset", imm, 64'd5);
      inst = 32'h0000007F; #1;
      check_val("id_err_in_reset", {61'b0, id_err}, 64'd0);
      inst = 32'h00500093;
      rst = 1'b0;
      @(posedge clk); #1;
      check_val("rst_sync_edge1", {63'b0, rst_sync}, 64'd1);
      @(posedge clk); #1;
      check_val("rst_sync_edge2", {63'b0, rst_sync}, 64'd0);

      apply(32'h00500093, 64'h0, 64'h10, 64'h0);
      check_val("addi_rd", {59'b0, rd_addr}, 64'd1);
      check_val("addi_imm", imm, 64'd5);
      check_val("addi_wen", {63'b0, rd_wen}, 64'd1);
      check_val("addi_res", exu_res, 64'h15);
      check_val("addi_lsu", {59'b0, lsu_opt}, 64'd1);

      apply(32'h002081BB, 64'h0, 64'h7FFF_FFFF, 64'h1);
      check_val("addw_res", exu_res, 64'hFFFF_FFFF_8000_0000);
      apply(32'h43F0D193, 64'h0, 64'h8000_0000_0000_0000, 64'h0);
      check_val("srai63_res", exu_res, 64'hFFFF_FFFF_FFFF_FFFF);

      apply(32'h0080B103, 64'h0, 64'h1000, 64'h0);
      check_val("ld_res", exu_res, 64'h1008);
      check_val("ld_lsu", {59'b0, lsu_opt}, 64'b01100);
      check_val("ld_wen", {63'b0, rd_wen}, 64'd1);
      apply(32'h0020B423, 64'h0, 64'h1000, 64'h0);
      check_val("sd_lsu", {59'b0, lsu_opt}, 64'b01111);
      check_val("sd_wen", {63'b0, rd_wen}, 64'd0);
      check_val("sd_imm", imm, 64'd8);

      apply(32'h00208463, 64'h0, '1, 64'd1);
      check_val("beq_zero", {63'b0, zero}, 64'd0);
      check_val("beq_brch", {63'b0, brch}, 64'd1);
      apply(32'h00209463, 64'h0, '1, 64'd1);
      check_val("bne_zero", {63'b0, zero}, 64'd1);
      apply(32'h0020C463, 64'h0, '1, 64'd1);
      check_val("blt_zero", {63'b0, zero}, 64'd1);
      check_val("blt_imm", imm, 64'd8);
      apply(32'h0020E463, 64'h0, '1, 64'd1);
      check_val("bltu_zero", {63'b0, zero}, 64'd0);
      check_val("bltu_res", exu_res, 64'd1);

      apply(32'h010000EF, 64'h8000_0000, 64'h0, 64'h0);
      check_val("jal_flag", {63'b0, jal}, 64'd1);
      check_val("jal_res", exu_res, 64'h8000_0004);
      check_val("jal_imm", imm, 64'd16);

      apply(32'h0000007F, 64'h0, 64'h0, 64'h0);
      check_val("err_opcode", {61'b0, id_err}, 64'b001);
      check_val("err_opcode_wen", {63'b0, rd_wen}, 64'd0);
      apply(32'h000090E7, 64'h0, 64'h0, 64'h0);
      check_val("err_jalr_f3", {61'b0, id_err}, 64'b010);
      check_val("err_jalr_wen", {63'b0, rd_wen}, 64'd0);
      check_val("err_jalr_jalr", {63'b0, jalr}, 64'd0);
      check_val("err_jalr_lsu", {59'b0, lsu_opt}, 64'd1);
      apply(32'h4020F1B3, 64'h0, 64'h0, 64'h0);
      check_val("err_op_f7", {61'b0, id_err}, 64'b100);
      check_val("err_op_wen", {63'b0, rd_wen}, 64'd0);
      check_val("err_op_lsu", {59'b0, lsu_opt}, 64'd1);

      for (int it = 0; it < 400; it++) begin
         logic [31:0] ri;
         logic [63:0] ra, rb;
         int          sel;
         ri = $urandom;
         sel = $urandom_range(0, 12);
         ri[6:0] = (sel == 12) ? 7'($urandom) : opc_tab[sel];
         case ($urandom_range(0, 3))
            0: ri[31:25] = 7'h00;
            1: ri[31:25] = 7'h20;
            default: ;
         endcase
         ra = {$urandom, $urandom};
         rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
         if ($urandom_range(0, 3) == 0) ra = 64'($urandom_range(0, 70));
         apply(ri, {$urandom, $urandom}, ra, rb);
         check_model();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
